avl_pixel_writer: RTL and testbench
===================================

Name: avl_pixel_writer

Overview:
- Streaming store stage between the compute datapath (conv/relu/pool outputs) and the DDR3 Avalon-MM port.
- Accepts 16-bit pixels over a valid/ready stream and packs 8 pixels into each 128-bit Avalon word.
- Buffers packed words in a small FIFO and issues single-beat Avalon writes to consecutive addresses from a programmed base.
- Pulses write_done when the programmed word count has been committed, i.e. accepted by the controller.

Parameters:
- ADDR_W, 26, Avalon word-address width.
- DATA_W, 128, Avalon data width.
- PIX_W, 16, pixel width. DATA_W/PIX_W = PPW = 8 pixels per word.
- FIFO_DEPTH, 4, packed-word FIFO entries (power of 2, ≥2).
- CNT_W, 16, width of num_words.

Ports:
- iCLK  in  1  clock; all logic on rising edge.
- iRST  in  1  synchronous reset, active high.
- local_init_done  in  1  DDR3 calibration complete.
- start  in  1  one-cycle request to begin a transfer.
- base_addr  in  ADDR_W  first word address, sampled with start.
- num_words  in  CNT_W  number of 128-bit words to write, sampled with start.
- pix_valid  in  1  upstream pixel valid.
- pix_data  in  PIX_W  upstream pixel.
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready at the edge.
- avl_waitrequest_n  in  1  controller ready; the beat completes at an edge where avl_write && avl_waitrequest_n.
- avl_address  out  ADDR_W  write address.
- avl_writedata  out  DATA_W  write data.
- avl_write  out  1  write request.
- avl_read  out  1  tied 0.
- avl_burstbegin  out  1  equals avl_write (burstcount 1).
- busy  out  1  high from the edge after an accepted start until write_done.
- write_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: pix_ready=0, avl_write=0, avl_address=0, avl_writedata=0, busy=0, write_done=0. FIFO is empty; all counters are 0; state is IDLE.
- Reset mid-transfer: at the next edge every output returns to its reset value. Partial packed words and FIFO contents are discarded; no further beats are issued.
- FSM:
  - IDLE: start is accepted only when start && local_init_done. On acceptance, latch base_addr and num_words. If num_words==0 go to DONE, else go to RUN. Any other start is ignored.
  - RUN: packing and writing proceed concurrently. Go to DONE at the edge where the final beat completes (beats_done reaches num_words).
  - DONE: write_done=1 and busy=0 for exactly one cycle, then IDLE. start is ignored in DONE and in RUN.
- Packer:
  - pix_ready = (state==RUN) && (pixels_accepted < num_words*PPW) && (fifo_count < FIFO_DEPTH). pix_ready is combinational from registered state only.
  - The k-th accepted pixel of a word (k = 0..7) lands in bits [16k+15:16k].
  - On the edge the 8th pixel is accepted, the complete word (including that pixel) is pushed into the FIFO.
- FIFO: a push and pop on the same edge leaves fifo_count unchanged. The packer never pushes when full (guaranteed by pix_ready). The writer never pops when empty.
- Writer (registered outputs):
  - When avl_write==0 and the FIFO is non-empty, assert avl_write at the next edge with avl_writedata = FIFO head and avl_address = (base + beats_done) mod 2^ADDR_W.
  - avl_write, avl_address and avl_writedata stay stable while avl_waitrequest_n==0.
  - On a completing edge: pop the FIFO and increment beats_done. If another word is available (including one pushed on that same edge), keep avl_write=1 and present the next word/address in the following cycle, giving back-to-back beats. Otherwise drop avl_write.
  - Latency: the first avl_write rises one edge after the 8th pixel's accept edge.
- Address wrap: the address increments modulo 2^ADDR_W with no error indication.
- Upstream stall: holding pix_valid low only delays packing; no timeout.

Test Plan:
1. Basic write:
   - Stimulus: base=0x100, num_words=2, pixels 0x0000..0x000F streamed continuously, waitrequest_n=1.
   - Required: beat0 at 0x100 with data 0x0007_0006_0005_0004_0003_0002_0001_0000; beat1 at 0x101 with data 0x000F_…_0008.
   - Required: write_done pulses once for 1 cycle; busy is 0 afterwards.
2. Backpressure:
   - Stimulus: num_words=8, waitrequest_n=0 for 40 cycles, then 1.
   - Required: address, data and write are stable throughout the stall. pix_ready drops once 4 words are queued (32 pixels accepted).
   - Required: after release, beats complete back-to-back at 8 consecutive addresses.
3. Zero length:
   - Stimulus: num_words=0.
   - Required: write_done is high in the cycle after start; avl_write is never asserted; pix_ready stays 0.
4. Address wrap:
   - Stimulus: base=0x3FFFFFF, num_words=2.
   - Required: addresses 0x3FFFFFF then 0x0000000.
5. Reset mid-transfer:
   - Stimulus: assert iRST after 1.5 words.
   - Required: at the next edge avl_write=0, pix_ready=0, busy=0.
   - Required: a new start (base=0, num_words=1) writes only the fresh 8 pixels.
6. Start gating:
   - Stimulus: start with local_init_done=0, and start while busy.
   - Required: both are ignored; the original transfer's count and addresses are unchanged.

Source files
------------

// File: rtl/avl_pixel_writer_if.sv
// Avalon-MM write port between the pixel writer and the DDR3 controller.
interface avl_pixel_writer_if #(
    parameter int ADDR_W = 26,
    parameter int DATA_W = 128
);
    logic              avl_waitrequest_n;
    logic [ADDR_W-1:0] avl_address;
    logic [DATA_W-1:0] avl_writedata;
    logic              avl_write;
    logic              avl_read;
    logic              avl_burstbegin;

    modport master (
        input  avl_waitrequest_n,
        output avl_address,
        output avl_writedata,
        output avl_write,
        output avl_read,
        output avl_burstbegin
    );

    modport slave (
        output avl_waitrequest_n,
        input  avl_address,
        input  avl_writedata,
        input  avl_write,
        input  avl_read,
        input  avl_burstbegin
    );
endinterface

// File: rtl/avl_pixel_writer.sv
// Packs 16-bit pixels into 128-bit words and writes them to DDR3
// as single-beat Avalon-MM writes at consecutive word addresses.
module avl_pixel_writer #(
    parameter int ADDR_W     = 26,
    parameter int DATA_W     = 128,
    parameter int PIX_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              local_init_done,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              pix_ready,
    avl_pixel_writer_if.master avl,
    output logic              busy,
    output logic              write_done
);
    localparam int PPW    = DATA_W / PIX_W;
    localparam int PPW_LG = $clog2(PPW);
    localparam int FA_W   = $clog2(FIFO_DEPTH);
    localparam int FC_W   = FA_W + 1;
    localparam int PC_W   = CNT_W + PPW_LG;

    localparam logic [FC_W-1:0]   FIFO_FULL = FC_W'(FIFO_DEPTH);
    localparam logic [PPW_LG-1:0] LAST_IDX  = PPW_LG'(PPW - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  nwords_q;
    logic [PC_W-1:0]   pix_cnt;
    logic [CNT_W-1:0]  beats_done;
    logic [PPW_LG-1:0] pack_idx;
    logic [DATA_W-1:0] pack_buf;
    logic [DATA_W-1:0] pack_word;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [FA_W-1:0]   wr_ptr;
    logic [FA_W-1:0]   rd_ptr;
    logic [FC_W-1:0]   fifo_count;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    logic              pix_fire;
    logic              push;
    logic              beat;
    logic              last_beat;
    logic              more;
    logic [CNT_W-1:0]  beats_nxt;
    logic [FA_W-1:0]   rd_nxt;
    logic [DATA_W-1:0] next_data;
    logic [PC_W-1:0]   pix_total;

    assign pix_total = {nwords_q, {PPW_LG{1'b0}}};
    assign pix_ready = (state == S_RUN)
                    && (pix_cnt < pix_total)
                    && (fifo_count < FIFO_FULL);
    assign pix_fire  = pix_valid && pix_ready;
    assign push      = pix_fire && (pack_idx == LAST_IDX);
    assign beat      = wr_q && avl.avl_waitrequest_n;
    assign beats_nxt = beats_done + CNT_W'(1);
    assign last_beat = beat && (beats_nxt == nwords_q);
    assign rd_nxt    = rd_ptr + FA_W'(1);

    // After a pop the next head is either already queued or is the
    // word completing on this same edge.
    assign more      = (fifo_count > FC_W'(1)) || push;
    assign next_data = (fifo_count > FC_W'(1)) ? mem[rd_nxt] : pack_word;

    always_comb begin
        pack_word = pack_buf;
        for (int k = 0; k < PPW; k++) begin
            if (pack_idx == PPW_LG'(k)) begin
                pack_word[k*PIX_W +: PIX_W] = pix_data;
            end
        end
    end

    assign avl.avl_write         = wr_q;
    assign avl.avl_burstbegin    = wr_q;
    assign avl.avl_read          = 1'b0;
    assign avl.avl_address       = addr_q;
    assign avl.avl_writedata     = data_q;

    always_ff @(posedge iCLK) begin
        if (!iRST && push) begin
            mem[wr_ptr] <= pack_word;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            write_done <= 1'b0;
            base_q     <= '0;
            nwords_q   <= '0;
            pix_cnt    <= '0;
            beats_done <= '0;
            pack_idx   <= '0;
            pack_buf   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            if (pix_fire) begin
                pix_cnt  <= pix_cnt + PC_W'(1);
                pack_idx <= pack_idx + PPW_LG'(1);
                pack_buf <= pack_word;
            end

            if (push) begin
                wr_ptr <= wr_ptr + FA_W'(1);
            end
            if (beat) begin
                rd_ptr <= rd_nxt;
            end
            if (push && !beat) begin
                fifo_count <= fifo_count + FC_W'(1);
            end else if (!push && beat) begin
                fifo_count <= fifo_count - FC_W'(1);
            end

            if (!wr_q) begin
                if (fifo_count != '0) begin
                    wr_q   <= 1'b1;
                    data_q <= mem[rd_ptr];
                    addr_q <= base_q + ADDR_W'(beats_done);
                end
            end else if (beat) begin
                beats_done <= beats_nxt;
                if (more) begin
                    data_q <= next_data;
                    addr_q <= base_q + ADDR_W'(beats_nxt);
                end else begin
                    wr_q <= 1'b0;
                end
            end

            unique case (state)
                S_IDLE: begin
                    if (start && local_init_done) begin
                        base_q     <= base_addr;
                        nwords_q   <= num_words;
                        pix_cnt    <= '0;
                        beats_done <= '0;
                        pack_idx   <= '0;
                        if (num_words == '0) begin
                            state      <= S_DONE;
                            write_done <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (last_beat) begin
                        state      <= S_DONE;
                        busy       <= 1'b0;
                        write_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    write_done <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_avl_pixel_writer.sv
// Directed bench for avl_pixel_writer: packing, stalls, wrap,
// zero length, mid-transfer reset and start gating.
module tb_avl_pixel_writer;
    localparam int ADDR_W = 26;
    localparam int DATA_W = 128;
    localparam int PIX_W  = 16;
    localparam int CNT_W  = 16;

    logic              iCLK = 1'b0;
    logic              iRST = 1'b1;
    logic              local_init_done = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [CNT_W-1:0]  num_words = '0;
    logic              pix_valid = 1'b0;
    logic [PIX_W-1:0]  pix_data = '0;
    logic              pix_ready;
    logic              busy;
    logic              write_done;

    avl_pixel_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    avl_pixel_writer dut (
        .iCLK            (iCLK),
        .iRST            (iRST),
        .local_init_done (local_init_done),
        .start           (start),
        .base_addr       (base_addr),
        .num_words       (num_words),
        .pix_valid       (pix_valid),
        .pix_data        (pix_data),
        .pix_ready       (pix_ready),
        .avl             (bus.master),
        .busy            (busy),
        .write_done      (write_done)
    );

    always #5 iCLK = ~iCLK;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;
    int first_wr = -1;
    int c0 = 0;
    int stall_bad = 0;
    int n = 0;
    bit have = 0;
    bit wr_seen = 0;
    bit rdy_seen = 0;
    logic [15:0]       pix_next = '0;
    logic [ADDR_W-1:0] h_a;
    logic [DATA_W-1:0] h_d;
    logic [ADDR_W-1:0] ba[$];
    logic [DATA_W-1:0] bd[$];
    int                bc[$];

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] word_of(logic [15:0] p0);
        logic [DATA_W-1:0] w;
        for (int k = 0; k < 8; k++) w[k*16 +: 16] = p0 + 16'(k);
        return w;
    endfunction

    function automatic logic [ADDR_W-1:0] beat_a(int i);
        return (i < ba.size()) ? ba[i] : '1;
    endfunction

    function automatic logic [DATA_W-1:0] beat_d(int i);
        return (i < bd.size()) ? bd[i] : '1;
    endfunction

    // Samples what the DUT presents to the coming edge, then advances.
    task automatic tick();
        bit fire;
        fire = pix_valid && pix_ready;
        if (bus.avl_write) wr_seen = 1;
        if (pix_ready) rdy_seen = 1;
        if (write_done) done_cnt++;
        if (bus.avl_write && bus.avl_waitrequest_n) begin
            ba.push_back(bus.avl_address);
            bd.push_back(bus.avl_writedata);
            bc.push_back(cyc);
        end
        @(posedge iCLK);
        #1;
        cyc++;
        if (fire) begin
            pix_next++;
            pix_data = pix_next;
        end
        if (bus.avl_write && first_wr < 0) first_wr = cyc;
    endtask

    task automatic wait_done(string tag);
        int k;
        k = 0;
        while (done_cnt == 0 && k < 300) begin
            tick();
            k++;
        end
        chk(tag, done_cnt != 0, 1);
    endtask

    task automatic clear();
        ba.delete();
        bd.delete();
        bc.delete();
        done_cnt = 0;
    endtask

    task automatic go(logic [ADDR_W-1:0] a, logic [CNT_W-1:0] w,
                      logic [15:0] p0);
        clear();
        base_addr = a;
        num_words = w;
        pix_next  = p0;
        pix_data  = p0;
        pix_valid = 1'b1;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    initial begin
        bus.avl_waitrequest_n = 1'b1;
        repeat (3) tick();
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_write", bus.avl_write, 0);
        chk("rst_addr", bus.avl_address, 0);
        chk("rst_data", bus.avl_writedata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", write_done, 0);
        chk("rst_read", bus.avl_read, 0);
        iRST = 1'b0;
        local_init_done = 1'b1;
        tick();

        // Basic two-word transfer
        first_wr = -1;
        go(26'h100, 16'd2, 16'h0000);
        c0 = cyc;
        chk("t1_busy", busy, 1);
        wait_done("t1_done_seen");
        repeat (3) tick();
        pix_valid = 1'b0;
        chk("t1_latency", first_wr, c0 + 9);
        chk("t1_nbeats", ba.size(), 2);
        chk("t1_addr0", beat_a(0), 26'h100);
        chk("t1_data0", beat_d(0),
            128'h0007_0006_0005_0004_0003_0002_0001_0000);
        chk("t1_addr1", beat_a(1), 26'h101);
        chk("t1_data1", beat_d(1),
            128'h000F_000E_000D_000C_000B_000A_0009_0008);
        chk("t1_done_cycles", done_cnt, 1);
        chk("t1_busy_after", busy, 0);
        chk("t1_pixels", pix_next, 16'd16);

        // Backpressure
        bus.avl_waitrequest_n = 1'b0;
        go(26'h200, 16'd8, 16'h0100);
        have = 0;
        stall_bad = 0;
        repeat (40) begin
            tick();
            if (bus.avl_write) begin
                if (!have) begin
                    have = 1;
                    h_a = bus.avl_address;
                    h_d = bus.avl_writedata;
                end else if (bus.avl_address !== h_a ||
                             bus.avl_writedata !== h_d) begin
                    stall_bad++;
                end
            end else if (have) begin
                stall_bad++;
            end
        end
        chk("t2_stall_stable", stall_bad, 0);
        chk("t2_stall_write", have, 1);
        chk("t2_held_addr", h_a, 26'h200);
        chk("t2_held_data", h_d, word_of(16'h0100));
        chk("t2_accepted", pix_next - 16'h0100, 16'd32);
        chk("t2_ready_low", pix_ready, 0);
        chk("t2_no_beat", ba.size(), 0);
        bus.avl_waitrequest_n = 1'b1;
        wait_done("t2_done_seen");
        repeat (3) tick();
        pix_valid = 1'b0;
        chk("t2_nbeats", ba.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_addr%0d", i), beat_a(i), 26'h200 + 26'(i));
            chk($sformatf("t2_data%0d", i), beat_d(i),
                word_of(16'h0100 + 16'(8 * i)));
        end
        chk("t2_b2b", (bc.size() >= 4) ? bc[3] - bc[0] : -1, 3);
        chk("t2_done_cycles", done_cnt, 1);

        // Zero length
        wr_seen = 0;
        rdy_seen = 0;
        go(26'h10, 16'd0, 16'h0000);
        chk("t3_done_next", write_done, 1);
        chk("t3_busy", busy, 0);
        tick();
        chk("t3_done_drop", write_done, 0);
        repeat (5) tick();
        pix_valid = 1'b0;
        chk("t3_no_write", wr_seen, 0);
        chk("t3_no_ready", rdy_seen, 0);
        chk("t3_done_cycles", done_cnt, 1);

        // Address wrap
        go(26'h3FFFFFF, 16'd2, 16'h0200);
        wait_done("t4_done_seen");
        repeat (3) tick();
        pix_valid = 1'b0;
        chk("t4_nbeats", ba.size(), 2);
        chk("t4_addr0", beat_a(0), 26'h3FFFFFF);
        chk("t4_addr1", beat_a(1), 26'h0000000);
        chk("t4_data1", beat_d(1), word_of(16'h0208));

        // Reset after one and a half words
        go(26'h300, 16'd4, 16'h0500);
        n = 0;
        while (pix_next - 16'h0500 < 16'd12 && n < 100) begin
            tick();
            n++;
        end
        chk("t5_reached", pix_next - 16'h0500, 16'd12);
        iRST = 1'b1;
        tick();
        chk("t5_write", bus.avl_write, 0);
        chk("t5_ready", pix_ready, 0);
        chk("t5_busy", busy, 0);
        iRST = 1'b0;
        tick();
        go(26'h0, 16'd1, 16'h0700);
        wait_done("t5_done_seen");
        repeat (3) tick();
        pix_valid = 1'b0;
        chk("t5_nbeats", ba.size(), 1);
        chk("t5_addr", beat_a(0), 26'h0);
        chk("t5_data", beat_d(0), word_of(16'h0700));

        // Start gating
        local_init_done = 1'b0;
        base_addr = 26'h50;
        num_words = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_nocal_busy", busy, 0);
        tick();
        chk("t6_nocal_idle", busy, 0);
        local_init_done = 1'b1;
        go(26'h400, 16'd2, 16'h0800);
        chk("t6_busy", busy, 1);
        repeat (4) tick();
        base_addr = 26'h999;
        num_words = 16'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t6_done_seen");
        repeat (3) tick();
        pix_valid = 1'b0;
        chk("t6_nbeats", ba.size(), 2);
        chk("t6_addr0", beat_a(0), 26'h400);
        chk("t6_addr1", beat_a(1), 26'h401);
        chk("t6_pixels", pix_next - 16'h0800, 16'd16);
        chk("t6_done_cycles", done_cnt, 1);
        chk("t6_busy_after", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
